// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two-channel button synchronizer, debouncer and press/long-press pulser
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   rs_raw    raw roll/stop button, asynchronous to clk
//   cl_raw    raw clear button, asynchronous to clk
//   rs_level  debounced rs state, 1 = pressed
//   cl_level  debounced cl state, 1 = pressed
//   rs_pulse  one-cycle strobe on debounced rs press
//   cl_pulse  one-cycle strobe on debounced cl press
//   rs_long   one-cycle strobe when rs has been held LONG_CNT ticks
//   cl_long   one-cycle strobe when cl has been held LONG_CNT ticks

module button_conditioner #(
  parameter int SAMPLE_DIV = 54000,
  parameter int STABLE_CNT = 20,
  parameter int LONG_CNT   = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic rs_raw,
  input  logic cl_raw,
  output logic rs_level,
  output logic cl_level,
  output logic rs_pulse,
  output logic cl_pulse,
  output logic rs_long,
  output logic cl_long
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int STAB_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam int HOLD_W = $clog2(LONG_CNT + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CNT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);

  // Channel index 0 = rs, 1 = cl.
  logic [1:0]        raw_n;
  logic [1:0]        sync_a;
  logic [1:0]        sync_b;
  logic [1:0]        level;
  logic [1:0]        level_d;
  logic [1:0]        pulse;
  logic [1:0]        long_p;
  logic [STAB_W-1:0] stab [2];
  logic [HOLD_W-1:0] hold [2];
  logic [DIV_W-1:0]  div;
  logic              tick;

  // Normalize so that 1 always means pressed; reset values of 0 then mean
  // "released" regardless of the board's button polarity.
  assign raw_n = {cl_raw, rs_raw} ^ {2{ACTIVE_LOW}};

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level   <= '0;
      level_d <= '0;
      pulse   <= '0;
      long_p  <= '0;
      for (int c = 0; c < 2; c++) begin
        stab[c] <= '0;
        hold[c] <= '0;
      end
    end else begin
      sync_a  <= raw_n;
      sync_b  <= sync_a;
      level_d <= level;
      pulse   <= level & ~level_d;
      long_p  <= '0;
      for (int c = 0; c < 2; c++) begin
        // Debounce: a differing sample must be seen on STABLE_CNT consecutive
        // ticks; any tick agreeing with the current level restarts the run.
        if (tick) begin
          if (sync_b[c] != level[c]) begin
            if (stab[c] == STAB_LAST) begin
              level[c] <= sync_b[c];
              stab[c]  <= '0;
            end else begin
              stab[c] <= stab[c] + 1'b1;
            end
          end else begin
            stab[c] <= '0;
          end
        end

        // Hold counter saturates at LONG_CNT so the long strobe fires once
        // per press; it fires on the tick that reaches the saturation value.
        if (!level[c]) begin
          hold[c] <= '0;
        end else if (tick && (hold[c] != HOLD_MAX)) begin
          hold[c]   <= hold[c] + 1'b1;
          long_p[c] <= (hold[c] == HOLD_LAST);
        end
      end
    end
  end

  assign rs_level = level[0];
  assign cl_level = level[1];
  assign rs_pulse = pulse[0];
  assign cl_pulse = pulse[1];
  assign rs_long  = long_p[0];
  assign cl_long  = long_p[1];

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Two-channel push-button front end placed directly upstream of the dice FSM. It synchronizes the raw "roll/stop" (rs) and "clear" (cl) switch inputs and debounces them on a slow sample tick. It then emits clean single-cycle press pulses, which the dice FSM consumes in place of its internal shift-register filtering. It also provides debounced levels and a long-press pulse per channel for later features (e.g. auto-roll).

Parameters:
SAMPLE_DIV, 54000, clk cycles per debounce sample tick (1 ms at 54 MHz); legal range >= 2
STABLE_CNT, 20, consecutive ticks a new input value must persist before the debounced level changes; legal range >= 1
LONG_CNT, 1000, ticks the debounced level must stay pressed before the long-press pulse fires; legal range >= 1
ACTIVE_LOW, 0, 1 = raw buttons read 0 when pressed; inputs are XORed with this value before synchronization

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
rs_raw  input  1  raw roll/stop button, asynchronous to clk
cl_raw  input  1  raw clear button, asynchronous to clk
rs_level  output  1  debounced rs state, 1 = pressed
cl_level  output  1  debounced cl state, 1 = pressed
rs_pulse  output  1  one-cycle strobe on debounced rs press
cl_pulse  output  1  one-cycle strobe on debounced cl press
rs_long  output  1  one-cycle strobe on rs long press
cl_long  output  1  one-cycle strobe on cl long press

Behaviour:
- Reset is asynchronous and active-low (reset=0 clears the block). It uses the single clock clk.
- In reset, all of the following go to 0: every output, synchronizer flops, tick divider, stability counters, hold counters, and the level-delay flops.
- Polarity: n = raw ^ ACTIVE_LOW. The value n passes through a 2-flop synchronizer per channel; the synchronized value is s.
- Tick divider: div counts 0..SAMPLE_DIV-1, then wraps to 0. tick=1 for exactly the one cycle in which div==SAMPLE_DIV-1. The divider is shared by both channels and is free-running.
- Debounce, per channel, evaluated only on tick cycles:
  - If s != level and stab == STABLE_CNT-1: level <= s and stab <= 0.
  - Else if s != level: stab <= stab+1.
  - Else: stab <= 0. Any bounce back to the current level restarts the count.
- Press pulse: pulse = level & ~level_d, registered. It asserts on the cycle after level rises and lasts exactly 1 cycle. A release produces no pulse.
- Long press:
  - hold counts ticks while level=1 and saturates at LONG_CNT.
  - On the tick where hold goes from LONG_CNT-1 to LONG_CNT, long asserts for 1 cycle (registered).
  - There is no repeat while the button is still held.
  - level=0 clears hold to 0 on the next cycle.
- Press latency: from a clean edge on raw to the pulse is 2 sync cycles + STABLE_CNT ticks (±1 tick of phase) + 1 cycle.
- Channels are fully independent. Simultaneous presses produce coincident pulses; no arbitration.
- Reset mid-operation: outputs drop to 0 immediately and asynchronously. If a button is still held when reset releases, it is treated as a new press: a pulse follows after STABLE_CNT ticks.
- ACTIVE_LOW=1 with idle-high raw inputs: because reset values are 0 after normalization, no spurious pulse occurs out of reset.
- Counter widths: $clog2 of the respective maximum. No overflow is possible because counters saturate or wrap as stated.
- Dice FSM hookup: rs_pulse drives rs and cl_pulse drives cl. The dice FSM's edge-filter condition (buffer==1) must then be replaced by direct pulse use.

Test Plan:
All scenarios use SAMPLE_DIV=4, STABLE_CNT=3, LONG_CNT=8, ACTIVE_LOW=0 unless noted.
1. Clean press: rs_raw 0->1, held for 40 cycles -> rs_level=1 within 2+12..16 cycles, exactly one rs_pulse, rs_long=0. Then release -> rs_level=0 after ~3 ticks, no pulse.
2. Bounce: cl_raw toggles every 4 cycles for 48 cycles, then stays 0 -> cl_level, cl_pulse and cl_long all stay 0 throughout.
3. Long press: rs_raw held for 60 cycles -> one rs_pulse, then one rs_long exactly 8 ticks (32 cycles) after rs_level rises, with no second rs_long. Release and re-hold -> a new pulse and a new long pulse.
4. Simultaneous: rs_raw and cl_raw rise in the same cycle -> rs_pulse and cl_pulse assert in the same cycle, both 1 cycle wide.
5. Reset mid-press: assert reset while rs_level=1 and the hold count is 5 -> all outputs 0 that cycle. Keep rs_raw held and deassert reset -> one rs_pulse 3 ticks later, and rs_long 8 ticks after that.
6. ACTIVE_LOW=1: raw inputs idle at 1 through and after reset -> no pulses or levels. Drive rs_raw to 0 for 5 ticks -> one rs_pulse, rs_level=1.
